state_sequencer: RTL

- Controller FSM for the sticky state-flag register pair (B and D flags, common synchronous clear).
- Generates the flag set pulses and the clear pulse, then confirms each flag through its read-back.
- Enforces a timeout between flag B and flag D, and reports progress, completion and error to the top-level game/control logic.

---
 rtl/state_sequencer.sv | 134 +++++++++++++
 1 files changed

// File: rtl/state_sequencer.sv
// Sequencer for the sticky B/D flag pair: clear, set B, confirm, await event, set D, confirm.
// Outputs are registered-state decodes; start->est_b_set 2 cycles, evento->est_d_set 1 cycle; no backpressure.
module state_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 50000000,
  parameter int unsigned CNT_W          = 26,
  parameter int unsigned CONFIRM_WAIT   = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             evento,
  input  logic             clear,
  input  logic             out_b,
  input  logic             out_d,
  output logic             est_b_set,
  output logic             est_d_set,
  output logic             reset_e,
  output logic [3:0]       state_o,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [CNT_W-1:0] count_o
);

  typedef enum logic [3:0] {
    IDLE    = 4'd0,
    CLR     = 4'd1,
    SET_B   = 4'd2,
    CONF_B  = 4'd3,
    WAIT_EV = 4'd4,
    SET_D   = 4'd5,
    CONF_D  = 4'd6,
    DONE    = 4'd7,
    ERR     = 4'd8
  } state_e;

  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CONFIRM_LAST = CNT_W'(CONFIRM_WAIT - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cnt_inc;
  // Remembers that the previous edge was an abort, so IDLE can emit the flag-clear pulse.
  logic             abort_q, abort_d;

  assign cnt_inc = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      abort_q <= abort_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    abort_d = 1'b0;
    if (clear && (state_q != IDLE)) begin
      state_d = IDLE;
      cnt_d   = '0;
      abort_d = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) state_d = CLR;
        end
        CLR: state_d = SET_B;
        SET_B: begin
          cnt_d   = '0;
          state_d = CONF_B;
        end
        CONF_B: begin
          if (out_b) begin
            cnt_d   = '0;
            state_d = WAIT_EV;
          end else if (cnt_q >= CONFIRM_LAST) begin
            state_d = ERR;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        WAIT_EV: begin
          // The event wins over a timeout landing on the same edge.
          if (evento) begin
            cnt_d   = cnt_inc;
            state_d = SET_D;
          end else if (cnt_q >= TIMEOUT_LAST) begin
            state_d = ERR;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        SET_D: begin
          cnt_d   = '0;
          state_d = CONF_D;
        end
        CONF_D: begin
          if (out_d) begin
            cnt_d   = '0;
            state_d = DONE;
          end else if (cnt_q >= CONFIRM_LAST) begin
            state_d = ERR;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        DONE: cnt_d = '0;
        ERR: cnt_d = cnt_q;
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_comb begin
    est_b_set = (state_q == SET_B);
    est_d_set = (state_q == SET_D);
    reset_e   = (state_q == CLR) || abort_q;
    state_o   = state_q;
    busy      = (state_q != IDLE) && (state_q != DONE) && (state_q != ERR);
    done      = (state_q == DONE);
    error     = (state_q == ERR);
    count_o   = cnt_q;
  end

endmodule
